// File: rtl/crossbar_pkg.sv
// Shared constants and helpers for the crossbar issue stage and crossbar array.
package crossbar_pkg;

  localparam int PIPELINE_NUM = 32;
  localparam int SELECT_WIDTH = 5;
  localparam int DATA_WIDTH   = 32;
  localparam int FIFO_DEPTH   = 4;

  typedef logic [DATA_WIDTH-1:0]   word_t;
  typedef logic [SELECT_WIDTH-1:0] dest_t;

  // Destination field lives in the low bits of every word.
  function automatic dest_t dest_of(input word_t word);
    return word[SELECT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/crossbar_issue_if.sv
// Producer-side and crossbar-side buses of the issue stage.
interface crossbar_issue_if #(
  parameter int PIPELINE_NUM = crossbar_pkg::PIPELINE_NUM,
  parameter int DATA_WIDTH   = crossbar_pkg::DATA_WIDTH
);

  logic [DATA_WIDTH*PIPELINE_NUM-1:0] in_data;
  logic [PIPELINE_NUM-1:0]            in_valid;
  logic [PIPELINE_NUM-1:0]            in_ready;
  logic [DATA_WIDTH*PIPELINE_NUM-1:0] out_data;
  logic [PIPELINE_NUM-1:0]            out_valid;

  // Environment side: producers drive words, crossbar consumes issued lanes.
  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid
  );

  // Issue stage side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/crossbar_issue_fifo.sv
// Per-source register FIFO with wrap-around pointers and an occupancy count.
module crossbar_issue_fifo #(
  parameter int WIDTH = crossbar_pkg::DATA_WIDTH,
  parameter int DEPTH = crossbar_pkg::FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage needs no reset: contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/crossbar_issue.sv
// Source-side issue stage: buffers per-source words and issues at most one
// word per destination per cycle, keeping every word in its own lane.
module crossbar_issue #(
  parameter int PIPELINE_NUM = crossbar_pkg::PIPELINE_NUM,
  parameter int SELECT_WIDTH = crossbar_pkg::SELECT_WIDTH,
  parameter int DATA_WIDTH   = crossbar_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH   = crossbar_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  crossbar_issue_if.slave       bus,
  output logic [31:0]           stall_count
);

  localparam int PN = PIPELINE_NUM;
  localparam int SW = SELECT_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [PN-1:0]    w_full;
  logic [PN-1:0]    w_empty;
  logic [PN-1:0]    w_push;
  logic [PN-1:0]    w_grant;
  logic             w_stall;
  logic [DW-1:0]    w_head        [PN];
  logic [PN-1:0]    w_req         [PN];
  logic [SW:0]      w_pick        [PN];
  logic [SW-1:0]    w_rr_ptr_nxt  [PN];
  logic [SW-1:0]    r_rr_ptr      [PN];
  logic [DW*PN-1:0] r_out_data;
  logic [PN-1:0]    r_out_valid;
  logic [31:0]      r_stall_count;

  // Round-robin pick: {found, index} of the first requester at or after ptr.
  // Scanning from the far end lets the nearest requester win by overwrite.
  function automatic logic [SW:0] rr_pick(input logic [PN-1:0] req,
                                          input logic [SW-1:0] ptr);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    for (int k = PN - 1; k >= 0; k--) begin
      idx = ptr + SW'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Ready reflects only fullness and is held low while in reset.
  assign bus.in_ready = ~w_full & {PN{rst}};
  assign w_push       = bus.in_valid & bus.in_ready;

  for (genvar i = 0; i < PN; i++) begin : g_fifo
    crossbar_issue_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (w_push[i]),
      .pop   (w_grant[i]),
      .din   (bus.in_data[DW*i +: DW]),
      .dout  (w_head[i]),
      .full  (w_full[i]),
      .empty (w_empty[i])
    );
  end

  // Per-destination request vectors from non-empty FIFO heads.
  always_comb begin
    for (int d = 0; d < PN; d++) begin
      w_req[d] = '0;
      for (int s = 0; s < PN; s++) begin
        w_req[d][s] = !w_empty[s] && (w_head[s][SW-1:0] == SW'(d));
      end
    end
  end

  // One arbiter per destination.
  always_comb begin
    for (int d = 0; d < PN; d++) begin
      w_pick[d] = rr_pick(w_req[d], r_rr_ptr[d]);
    end
  end

  // Each source requests a single destination, so grants never overlap.
  always_comb begin
    w_grant = '0;
    for (int d = 0; d < PN; d++) begin
      w_rr_ptr_nxt[d] = r_rr_ptr[d];
      if (w_pick[d][SW]) begin
        w_grant[w_pick[d][SW-1:0]] = 1'b1;
        w_rr_ptr_nxt[d]            = w_pick[d][SW-1:0] + SW'(1);
      end
    end
  end

  // Any waiting head left behind this cycle counts as contention.
  assign w_stall = |(~w_empty & ~w_grant);

  // Output registers, arbitration pointers and the contention counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data    <= '0;
      r_out_valid   <= '0;
      r_stall_count <= '0;
      for (int d = 0; d < PN; d++) r_rr_ptr[d] <= '0;
    end else begin
      r_out_valid <= w_grant;
      for (int i = 0; i < PN; i++) begin
        r_out_data[DW*i +: DW] <= w_grant[i] ? w_head[i] : '0;
      end
      for (int d = 0; d < PN; d++) r_rr_ptr[d] <= w_rr_ptr_nxt[d];
      if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_crossbar_issue.sv
// Bench for crossbar_issue: table rows, hand sequences, lane scoreboard.
module tb_crossbar_issue;
  import crossbar_pkg::*;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] stall_count;

  crossbar_issue_if #(.PIPELINE_NUM(N), .DATA_WIDTH(32)) bus ();

  crossbar_issue #(
    .PIPELINE_NUM (N),
    .SELECT_WIDTH (5),
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] sb_q [N][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted words per lane, compare issued words in order.
  logic [N-1:0] mon_seen;
  logic         mon_unique;
  logic         mon_zero;
  logic [4:0]   mon_d;
  logic [31:0]  mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) sb_q[i].delete();
    end else begin
      if (|bus.out_valid) begin
        mon_seen   = '0;
        mon_unique = 1'b1;
        mon_zero   = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (bus.out_valid[i]) begin
            mon_d = bus.out_data[32*i +: 5];
            if (mon_seen[mon_d]) mon_unique = 1'b0;
            mon_seen[mon_d] = 1'b1;
            if (sb_q[i].size() == 0) begin
              n_total++;
              $display("FAIL sb_stale lane %0d: got word %h, expected no issue", i, bus.out_data[32*i +: 32]);
            end else begin
              mon_exp = sb_q[i].pop_front();
              check($sformatf("sb_data lane %0d", i), bus.out_data[32*i +: 32], mon_exp);
            end
          end else if (bus.out_data[32*i +: 32] != 32'd0) begin
            mon_zero = 1'b0;
          end
        end
        check("dest_unique", {31'd0, mon_unique}, 32'd1);
        check("idle_lane_zero", {31'd0, mon_zero}, 32'd1);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid[i] && bus.in_ready[i]) sb_q[i].push_back(bus.in_data[32*i +: 32]);
      end
    end
  end

  task automatic do_reset();
    bus.in_valid = '0;
    bus.in_data  = '0;
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_out_data_or", {31'd0, |bus.out_data}, 32'd0);
    check("rst_in_ready", bus.in_ready, 32'd0);
    check("rst_stall", stall_count, 32'd0);
    repeat (3) tick();
    check("rst_hold_out_valid", bus.out_valid, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_release_in_ready", bus.in_ready, 32'hFFFF_FFFF);
  endtask

  function automatic logic [31:0] row_word(input int mode, input int d, input int i,
                                           input logic [31:0] base);
    int dest;
    case (mode)
      0:       dest = d;
      1:       dest = (i + 1) % N;
      2:       dest = i;
      default: dest = (i < 16) ? d : d + 1;
    endcase
    return base | 32'(dest);
  endfunction

  typedef struct {
    logic [31:0] mask;
    int          mode;
    int          d;
    logic [31:0] base;
    logic [31:0] ov2;
    logic [31:0] ov3;
    logic [31:0] stall;
  } row_t;

  row_t rows [7];

  int          seq_a, seq_b;
  logic        acc_a, acc_b, prev_a, prev_b;
  int          tog_a, tog_b;
  logic [31:0] ov_s;
  int          left;

  initial begin
    bus.in_valid = '0;
    bus.in_data  = '0;

    rows[0] = '{32'h0000_0008, 0, 5,  32'h0000_0100, 32'h0000_0008, 32'h0, 32'd0};
    rows[1] = '{32'hFFFF_FFFF, 1, 0,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'd0};
    rows[2] = '{32'hFFFF_FFFF, 2, 0,  32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 32'd0};
    rows[3] = '{32'hFFFF_FFFF, 0, 0,  32'h0000_1000, 32'h0000_0001, 32'h0000_0002, 32'd31};
    rows[4] = '{32'h0010_0220, 3, 3,  32'h0000_0800, 32'h0010_0020, 32'h0000_0200, 32'd1};
    rows[5] = '{32'hC000_0000, 2, 0,  32'h0000_2200, 32'hC000_0000, 32'h0, 32'd0};
    rows[6] = '{32'h0000_FFFF, 0, 31, 32'h0000_4000, 32'h0000_0001, 32'h0000_0002, 32'd15};

    // Table rows: one burst per row from a fresh reset.
    for (int r = 0; r < 7; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) bus.in_data[32*i +: 32] = row_word(rows[r].mode, rows[r].d, i, rows[r].base);
      bus.in_valid = rows[r].mask;
      tick();
      bus.in_valid = '0;
      check($sformatf("row%0d_ov_c1", r), bus.out_valid, 32'd0);
      tick();
      check($sformatf("row%0d_ov_c2", r), bus.out_valid, rows[r].ov2);
      tick();
      check($sformatf("row%0d_ov_c3", r), bus.out_valid, rows[r].ov3);
      repeat (40) tick();
      check($sformatf("row%0d_stall", r), stall_count, rows[r].stall);
    end

    // Three-way conflict on destination 7.
    do_reset();
    bus.in_data[31:0]  = 32'h0000_0007;
    bus.in_data[63:32] = 32'h0000_0027;
    bus.in_data[95:64] = 32'h0000_0047;
    bus.in_valid = 32'h7;
    tick();
    bus.in_valid = '0;
    check("tri_c1", bus.out_valid, 32'd0);
    tick();
    check("tri_c2", bus.out_valid, 32'h1);
    tick();
    check("tri_c3", bus.out_valid, 32'h2);
    tick();
    check("tri_c4", bus.out_valid, 32'h4);
    tick();
    check("tri_c5", bus.out_valid, 32'h0);
    check("tri_stall", stall_count, 32'd2);
    check("tri_rr_ptr7", 32'(dut.r_rr_ptr[7]), 32'd3);

    // Fairness and backpressure: lanes 0 and 31 flood destination 0.
    do_reset();
    seq_a = 0; seq_b = 0; tog_a = 0; tog_b = 0; prev_a = 1'b1; prev_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.in_data[31:0]     = 32'(seq_a) << 16;
      bus.in_data[1023:992] = (32'(seq_b) << 16) | 32'h0000_1F00;
      bus.in_valid          = 32'h8000_0001;
      @(negedge clk);
      acc_a = bus.in_ready[0];
      acc_b = bus.in_ready[31];
      ov_s  = bus.out_valid;
      if (acc_a != prev_a) tog_a++;
      if (acc_b != prev_b) tog_b++;
      prev_a = acc_a;
      prev_b = acc_b;
      if (k >= 2) check($sformatf("fair_alt k%0d", k), ov_s, (k % 2 == 0) ? 32'h1 : 32'h8000_0000);
      @(posedge clk);
      #1;
      if (acc_a) seq_a++;
      if (acc_b) seq_b++;
    end
    bus.in_valid = '0;
    repeat (20) tick();
    check("fair_ready0_toggles", {31'd0, tog_a >= 2}, 32'd1);
    check("fair_ready31_toggles", {31'd0, tog_b >= 2}, 32'd1);
    check("fair_accept_balance", {31'd0, (seq_a - seq_b <= 1) && (seq_b - seq_a <= 1)}, 32'd1);

    // Reset in the middle of heavy contention.
    do_reset();
    seq_a = 0;
    for (int k = 0; k < 12; k++) begin
      for (int i = 4; i <= 6; i++) bus.in_data[32*i +: 32] = (32'(seq_a) << 16) | (32'(i) << 8) | 32'd9;
      bus.in_valid = 32'h0000_0070;
      tick();
      seq_a++;
    end
    check("mid_some_full", {31'd0, bus.in_ready[6:4] != 3'b111}, 32'd1);
    check("mid_busy_before", {31'd0, bus.out_valid != 32'd0}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_out_valid", bus.out_valid, 32'd0);
    check("mid_out_data_or", {31'd0, |bus.out_data}, 32'd0);
    check("mid_stall", stall_count, 32'd0);
    check("mid_in_ready", bus.in_ready, 32'd0);
    bus.in_valid = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("mid_release_in_ready", bus.in_ready, 32'hFFFF_FFFF);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("mid_no_stale k%0d", k), bus.out_valid, 32'd0);
    end

    left = 0;
    for (int i = 0; i < N; i++) left += sb_q[i].size();
    check("sb_all_drained", 32'(left), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
